sram_word_responder: RTL and testbench

//  Responder side of the LSU data-memory request/ack handshake for external 16-bit SRAM (IS61WV25616 class).

---
 rtl/sram_word_responder_if.sv | 22 ++
 rtl/sram_word_responder.sv | 175 +++++++++++++++++
 tb/tb_sram_word_responder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_word_responder_if.sv
// LSU-side request/ack bundle for the SRAM word responder.
interface sram_word_responder_if;
  logic        i_cs;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic [3:0]  i_bmask;
  logic [31:0] o_ld_data;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_cs, i_lsu_wren, i_lsu_rden, i_lsu_addr, i_st_data, i_bmask,
    input  o_ld_data, o_ack, o_busy
  );

  modport slave (
    input  i_cs, i_lsu_wren, i_lsu_rden, i_lsu_addr, i_st_data, i_bmask,
    output o_ld_data, o_ack, o_busy
  );
endinterface

// File: rtl/sram_word_responder.sv
// Splits one 32-bit LSU access into two 16-bit SRAM accesses (low half, then high)
// and returns a one-cycle ack; every output comes straight from a flop.
module sram_word_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sram_word_responder_if.slave  lsu,
  output logic [17:0]           o_sram_addr,
  inout  wire  [15:0]           io_sram_dq,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic                  o_sram_lb_n,
  output logic                  o_sram_ub_n
);
  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      addr_q, addr_d;
  logic [31:0]      st_q, st_d;
  logic [3:0]       bmask_q, bmask_d;
  logic             wr_q, wr_d;
  logic [15:0]      ld_lo_q, ld_lo_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [17:0]      sram_addr_q, sram_addr_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             lb_n_q, lb_n_d;
  logic             ub_n_q, ub_n_d;
  logic             dq_oe_q, dq_oe_d;
  logic [15:0]      dq_out_q, dq_out_d;

  logic req, accept, last, in_phase, hi_phase;
  logic unused_addr_bits;

  assign req  = lsu.i_cs & (lsu.i_lsu_wren | lsu.i_lsu_rden);
  assign last = (cnt_q == CNT_LAST);
  assign unused_addr_bits = ^{lsu.i_lsu_addr[31:19], lsu.i_lsu_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = S_LO;
          cnt_d   = '0;
        end
      end
      S_LO: begin
        if (last) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (last) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the pins change on the same edge as the FSM.
  always_comb begin
    addr_d  = addr_q;
    st_d    = st_q;
    bmask_d = bmask_q;
    wr_d    = wr_q;
    if (accept) begin
      addr_d  = lsu.i_lsu_addr[18:2];
      st_d    = lsu.i_st_data;
      bmask_d = lsu.i_bmask;
      wr_d    = lsu.i_lsu_wren;
    end

    in_phase = (state_d == S_LO) || (state_d == S_HI);
    hi_phase = (state_d == S_HI);

    ce_n_d = ~in_phase;
    oe_n_d = ~(in_phase & ~wr_d);
    we_n_d = ~(in_phase & wr_d & (cnt_d != '0));
    lb_n_d = 1'b1;
    ub_n_d = 1'b1;
    if (in_phase) begin
      if (wr_d) begin
        lb_n_d = hi_phase ? ~bmask_d[2] : ~bmask_d[0];
        ub_n_d = hi_phase ? ~bmask_d[3] : ~bmask_d[1];
      end else begin
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end

    sram_addr_d = in_phase ? {addr_d, hi_phase} : sram_addr_q;
    dq_oe_d     = in_phase & wr_d;
    dq_out_d    = hi_phase ? st_d[31:16] : st_d[15:0];
    ack_d       = (state_d == S_ACK);
    busy_d      = (state_d != S_IDLE);

    // Read halves are sampled on the edge that closes each phase.
    ld_lo_d   = ld_lo_q;
    ld_data_d = ld_data_q;
    if (!wr_q && last) begin
      if (state_q == S_LO) ld_lo_d = io_sram_dq;
      if (state_q == S_HI) ld_data_d = {io_sram_dq, ld_lo_q};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      ld_data_q   <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ld_data_q   <= ld_data_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  always_ff @(posedge i_clk) begin
    addr_q   <= addr_d;
    st_q     <= st_d;
    bmask_q  <= bmask_d;
    wr_q     <= wr_d;
    dq_out_q <= dq_out_d;
    ld_lo_q  <= ld_lo_d;
  end

  assign io_sram_dq    = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_sram_addr   = sram_addr_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_we_n   = we_n_q;
  assign o_sram_lb_n   = lb_n_q;
  assign o_sram_ub_n   = ub_n_q;
  assign lsu.o_ld_data = ld_data_q;
  assign lsu.o_ack     = ack_q;
  assign lsu.o_busy    = busy_q;
endmodule

// File: tb/tb_sram_word_responder.sv
// Bench for sram_word_responder: pin-level SRAM model plus a word-level reference memory,
// two DUTs (WAIT_CYCLES 2 and 4) sharing one stimulus bus selected by sel.
module tb_sram_word_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel, probe, cs, wren, rden;
  logic [31:0] addr, st;
  logic [3:0]  mask;
  int total = 0;
  int bad   = 0;

  sram_word_responder_if if2 ();
  sram_word_responder_if if4 ();

  logic [17:0] a2, a4;
  wire  [15:0] dq2, dq4;
  logic ce2, oe2, we2, lb2, ub2, ce4, oe4, we4, lb4, ub4;

  assign if2.i_cs = cs & ~sel;
  assign if2.i_lsu_wren = wren;
  assign if2.i_lsu_rden = rden;
  assign if2.i_lsu_addr = addr;
  assign if2.i_st_data  = st;
  assign if2.i_bmask    = mask;
  assign if4.i_cs = cs & sel;
  assign if4.i_lsu_wren = wren;
  assign if4.i_lsu_rden = rden;
  assign if4.i_lsu_addr = addr;
  assign if4.i_st_data  = st;
  assign if4.i_bmask    = mask;

  sram_word_responder #(.WAIT_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .lsu(if2), .o_sram_addr(a2), .io_sram_dq(dq2),
    .o_sram_ce_n(ce2), .o_sram_oe_n(oe2), .o_sram_we_n(we2), .o_sram_lb_n(lb2), .o_sram_ub_n(ub2)
  );
  sram_word_responder #(.WAIT_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .lsu(if4), .o_sram_addr(a4), .io_sram_dq(dq4),
    .o_sram_ce_n(ce4), .o_sram_oe_n(oe4), .o_sram_we_n(we4), .o_sram_lb_n(lb4), .o_sram_ub_n(ub4)
  );

  logic        v_ce, v_oe, v_we, v_lb, v_ub, v_ack, v_busy;
  logic [17:0] v_addr;
  logic [15:0] v_dq;
  logic [31:0] v_ld;
  assign v_ce   = sel ? ce4 : ce2;
  assign v_oe   = sel ? oe4 : oe2;
  assign v_we   = sel ? we4 : we2;
  assign v_lb   = sel ? lb4 : lb2;
  assign v_ub   = sel ? ub4 : ub2;
  assign v_addr = sel ? a4 : a2;
  assign v_dq   = sel ? dq4 : dq2;
  assign v_ack  = sel ? if4.o_ack : if2.o_ack;
  assign v_busy = sel ? if4.o_busy : if2.o_busy;
  assign v_ld   = sel ? if4.o_ld_data : if2.o_ld_data;

  // Pin-level SRAM: drives dq while read-enabled; probe forces 0 to expose any DUT driver.
  logic [15:0] mem [0:262143];
  logic sram_rd;
  assign sram_rd = ~v_ce & ~v_oe & v_we;
  assign dq2 = (!sel && probe) ? 16'h0000 : (!sel && sram_rd) ? mem[v_addr] : 16'hzzzz;
  assign dq4 = ( sel && probe) ? 16'h0000 : ( sel && sram_rd) ? mem[v_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!v_ce && !v_we) begin
      if (!v_lb) mem[v_addr][7:0]  <= v_dq[7:0];
      if (!v_ub) mem[v_addr][15:8] <= v_dq[15:8];
    end
  end

  // Word-level reference memory keyed by word address.
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_ld [2];

  int          ce_cnt, we_cnt, oe_cnt;
  logic        first_we, busy_ack;
  logic [1:0]  lo_l, hi_l;
  logic [17:0] lo_a, hi_a;
  logic [31:0] ld_at_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic r, input logic c, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit wiggle,
                        input bit hold, output int lat);
    @(negedge clk);
    cs = c; wren = w; rden = r; addr = a; st = d; mask = m;
    ce_cnt = 0; we_cnt = 0; oe_cnt = 0; lat = 0; first_we = 1'b0; busy_ack = 1'b0;
    lo_l = 2'b00; hi_l = 2'b00; lo_a = '0; hi_a = '0; ld_at_ack = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (wiggle && n == 2) begin cs = 1'b0; addr = ~a; st = ~d; mask = ~m; end
      if (wiggle && n == 3) begin cs = 1'b1; wren = ~w; rden = 1'b1; end
      if (!v_ce) begin
        ce_cnt++;
        if (!v_we) we_cnt++;
        if (!v_oe) oe_cnt++;
        if (ce_cnt == 1) begin lo_l = {v_ub, v_lb}; lo_a = v_addr; first_we = v_we; end
        hi_l = {v_ub, v_lb};
        hi_a = v_addr;
      end
      if (v_ack) begin lat = n; busy_ack = v_busy; ld_at_ack = v_ld; break; end
    end
    if (!hold) begin
      cs = 1'b0; wren = 1'b0; rden = 1'b0;
      if (lat != 0) begin
        @(negedge clk);
        chk("ack_one_cycle", v_ack, 0);
        chk("busy_after_ack", v_busy, 0);
      end
    end
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic both, input bit wiggle);
    int lat, w;
    logic [16:0] k;
    logic [31:0] t;
    w = sel ? 4 : 2;
    k = a[18:2];
    access(1'b1, both, 1'b1, a, d, m, wiggle, 1'b0, lat);
    t = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) t[8*b +: 8] = d[8*b +: 8];
    ref_mem[k] = t;
    chk("wr_latency", lat, 2 * w + 1);
    chk("wr_ce_cycles", ce_cnt, 2 * w);
    chk("wr_we_cycles", we_cnt, 2 * (w - 1));
    chk("wr_oe_cycles", oe_cnt, 0);
    chk("wr_setup_we", first_we, 1);
    chk("wr_lanes_lo", lo_l, {~m[1], ~m[0]});
    chk("wr_lanes_hi", hi_l, {~m[3], ~m[2]});
    chk("wr_addr_lo", lo_a, {k, 1'b0});
    chk("wr_addr_hi", hi_a, {k, 1'b1});
    chk("wr_busy_at_ack", busy_ack, 1);
    chk("wr_ld_unchanged", v_ld, last_ld[sel]);
  endtask

  task automatic rd_word(input logic [31:0] a, input bit wiggle);
    int lat, w;
    logic [16:0] k;
    w = sel ? 4 : 2;
    k = a[18:2];
    access(1'b0, 1'b1, 1'b1, a, 32'h0, 4'h0, wiggle, 1'b0, lat);
    chk("rd_latency", lat, 2 * w + 1);
    chk("rd_ce_cycles", ce_cnt, 2 * w);
    chk("rd_oe_cycles", oe_cnt, 2 * w);
    chk("rd_we_cycles", we_cnt, 0);
    chk("rd_lanes", {lo_l, hi_l}, 4'b0000);
    chk("rd_addr_lo", lo_a, {k, 1'b0});
    chk("rd_addr_hi", hi_a, {k, 1'b1});
    chk("rd_data", ld_at_ack, ref_mem[k]);
    chk("rd_data_held", v_ld, ref_mem[k]);
    last_ld[sel] = ref_mem[k];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra [6];
  int lat, gap;

  initial begin
    rst = 1'b1; sel = 1'b0; probe = 1'b0; cs = 1'b0; wren = 1'b0; rden = 1'b0;
    addr = '0; st = '0; mask = '0;
    last_ld[0] = '0; last_ld[1] = '0;
    repeat (2) @(negedge clk);
    probe = 1'b1;
    #1;
    chk("rst_ack", if2.o_ack, 0);
    chk("rst_busy", if2.o_busy, 0);
    chk("rst_ld", if2.o_ld_data, 0);
    chk("rst_addr", a2, 0);
    chk("rst_ctrl", {ce2, oe2, we2, lb2, ub2}, 5'b11111);
    chk("rst_dq_hiz", dq2, 0);
    chk("rst4_ld", if4.o_ld_data, 0);
    probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of the high-half strobe.
    @(negedge clk);
    cs = 1'b1; wren = 1'b1; addr = 32'h100; st = 32'hDEADBEEF; mask = 4'hF;
    repeat (4) @(negedge clk);
    chk("pre_rst_we", v_we, 0);
    chk("pre_rst_addr", v_addr, 18'h81);
    rst = 1'b1;
    #1;
    probe = 1'b1;
    #1;
    chk("midrst_we", v_we, 1);
    chk("midrst_ce", v_ce, 1);
    chk("midrst_dq_hiz", v_dq, 0);
    chk("midrst_ack", v_ack, 0);
    chk("midrst_busy", v_busy, 0);
    probe = 1'b0; cs = 1'b0; wren = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    wr_word(32'h0000_2004, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    chk("sram_lo_half", mem[18'h01002], 16'hBEEF);
    chk("sram_hi_half", mem[18'h01003], 16'hDEAD);
    rd_word(32'h0000_2004, 1'b0);
    chk("rd_deadbeef", ld_at_ack, 32'hDEADBEEF);
    rd_word(32'h0008_2007, 1'b0);
    chk("rd_alias", ld_at_ack, 32'hDEADBEEF);

    wr_word(32'h0000_3000, 32'h0, 4'hF, 1'b0, 1'b0);
    wr_word(32'h0000_3000, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    rd_word(32'h0000_3000, 1'b0);
    chk("mask_0101", ld_at_ack, 32'h00220044);

    wr_word(32'h0000_3000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    rd_word(32'h0000_3000, 1'b0);
    chk("both_en_write", ld_at_ack, 32'hCAFEF00D);

    access(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b0, 1'b0, lat);
    chk("cs0_no_ack", lat, 0);
    chk("cs0_no_sram", ce_cnt, 0);

    // Request held through the ack starts a second read from IDLE.
    access(1'b0, 1'b1, 1'b1, 32'h0000_2004, 32'h0, 4'h0, 1'b0, 1'b1, lat);
    chk("b2b_first_lat", lat, 5);
    chk("b2b_first_data", ld_at_ack, 32'hDEADBEEF);
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (v_ack) begin gap = n; break; end
    end
    cs = 1'b0; rden = 1'b0;
    chk("b2b_gap", gap, 6);
    chk("b2b_second_data", v_ld, 32'hDEADBEEF);
    last_ld[0] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("b2b_idle", v_busy, 0);

    wr_word(32'h0000_4000, 32'h55AA1234, 4'hF, 1'b0, 1'b1);
    rd_word(32'h0000_4000, 1'b1);
    chk("wiggle_data", ld_at_ack, 32'h55AA1234);
    wr_word(32'h0000_4000, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    rd_word(32'h0000_4000, 1'b0);
    chk("mask_0000", ld_at_ack, 32'h55AA1234);

    for (int i = 0; i < 6; i++) begin
      ra[i] = $urandom;
      wr_word(ra[i], $urandom, 4'hF, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      int j;
      j = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1)
        wr_word(ra[j], $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      else
        rd_word(ra[j], 1'b0);
    end

    @(negedge clk);
    sel = 1'b1;
    wr_word(32'h0000_0010, 32'hA5A55A5A, 4'hF, 1'b0, 1'b0);
    wr_word(32'h0000_0010, 32'h0000FFFF, 4'b1100, 1'b0, 1'b0);
    rd_word(32'h0000_0010, 1'b0);
    chk("w4_data", ld_at_ack, 32'h00005A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
